spi_mic_sample_scheduler: RTL

//  Sequences the SPI microphone sampler: issues a one-cycle sample request every RATE_DIV clocks,

---
 rtl/spi_mic_sample_scheduler_pkg.sv | 19 +
 rtl/spi_mic_sample_scheduler_fifo.sv | 64 ++++++
 rtl/spi_mic_sample_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/spi_mic_sample_scheduler_pkg.sv
// Shared types and helpers for the SPI microphone sample scheduler.
package spi_mic_pkg;

    localparam int DATA_W_DEF = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_TICK = 3'd1,
        START     = 3'd2,
        BUSY      = 3'd3,
        CAPTURE   = 3'd4
    } state_t;

    // Sample periods below two clocks cannot fit a terminal count, so clamp them.
    function automatic logic [15:0] eff_period(input logic [15:0] rate);
        return (rate < 16'd2) ? 16'd2 : rate;
    endfunction

endpackage

// File: rtl/spi_mic_sample_scheduler_fifo.sv
// Sample FIFO with registered read port and a separate occupancy counter.
module sample_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (level == {(AW+1){1'b0}});
    assign full    = (level == FULL_LVL);
    assign pop_ok  = pop && !empty;
    // A full FIFO still takes a push when a pop frees a slot in the same cycle.
    assign push_ok = push && (!full || pop_ok);

    // Storage array write port.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers, occupancy and registered read port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop_ok;
            if (pop_ok) begin
                rd_data <= mem[rd_ptr];
                rd_ptr  <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/spi_mic_sample_scheduler.sv
// Paces SPI microphone transfers, captures completed samples into a FIFO and
// raises a watermark interrupt plus sticky overflow/timeout error flags.
module spi_mic_sample_scheduler
    import spi_mic_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 16,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [15:0]              rate_div,
    input  logic [$clog2(DEPTH):0]   watermark,
    output logic                     spi_start,
    input  logic                     spi_cs_b,
    input  logic [DATA_W-1:0]        spi_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     irq,
    output logic                     overflow,
    output logic                     timeout_err,
    input  logic                     clr_err
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t          state;
    logic [15:0]     tick_cnt;
    logic [15:0]     period;
    logic            tick;
    logic            cs_b_q;
    logic            cs_rise;
    logic [TW-1:0]   tmo_cnt;
    logic            tmo_hit;
    logic            push;
    logic            fifo_full;
    logic            fifo_empty;
    logic            drop;
    logic            tick_lost;

    assign tick      = enable && (tick_cnt == (period - 16'd1));
    assign cs_rise   = spi_cs_b && !cs_b_q;
    assign tmo_hit   = (state == BUSY) && !cs_rise && (tmo_cnt >= TW'(TIMEOUT));
    assign push      = (state == CAPTURE);
    assign drop      = push && fifo_full && !(rd_en && !fifo_empty);
    assign tick_lost = tick && ((state == START) || (state == BUSY) || (state == CAPTURE));
    assign irq       = (watermark != '0) && (level >= watermark);

    // Free-running sample-period counter; the period is re-latched only at wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= 16'd0;
            period   <= 16'd2;
        end else if (!enable || tick) begin
            tick_cnt <= 16'd0;
            period   <= eff_period(rate_div);
        end else begin
            tick_cnt <= tick_cnt + 16'd1;
        end
    end

    // Delayed chip-select copy for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_b_q <= 1'b1;
        end else begin
            cs_b_q <= spi_cs_b;
        end
    end

    // Transfer sequencer with registered start strobe and timeout counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            spi_start <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            spi_start <= 1'b0;
            case (state)
                IDLE: begin
                    state <= enable ? WAIT_TICK : IDLE;
                end
                WAIT_TICK: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        state     <= START;
                        spi_start <= 1'b1;
                    end else begin
                        state <= WAIT_TICK;
                    end
                end
                START: begin
                    state   <= BUSY;
                    tmo_cnt <= TW'(1);
                end
                BUSY: begin
                    if (cs_rise) begin
                        state <= CAPTURE;
                    end else if (tmo_hit) begin
                        state <= enable ? WAIT_TICK : IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end
                CAPTURE: begin
                    state <= enable ? WAIT_TICK : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky error flags; a same-cycle set beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (drop || tick_lost) begin
                overflow <= 1'b1;
            end else if (clr_err) begin
                overflow <= 1'b0;
            end else begin
                overflow <= overflow;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end else begin
                timeout_err <= timeout_err;
            end
        end
    end

    sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .wr_data  (spi_data),
        .pop      (rd_en),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .level    (level),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule
